mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle MEM-stage load/store datapath.
- Accepts one load/store per request from the EX/MEM boundary and runs a bus transaction with req/ack handshake. It stalls the pipeline until the access completes, then returns lane-extracted, sign/zero-extended load data.
- Also detects misaligned accesses and bus timeouts, and reports them as exception codes to the MEM exception logic.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, bus/data width in bits; legal values 32 or 64.
- TIMEOUT, 255, ack wait cycles before a bus error is raised; legal range 1..65535.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request present
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64)
- req_signed_i  in  1  loads: 1 = sign-extend, 0 = zero-extend
- req_addr_i  in  ADDR_W  physical byte address
- req_wdata_i  in  DATA_W  store data, right-aligned
- flush_i  in  1  discard current/pending access
- stall_o  out  1  pipeline hold
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  DATA_W  extended load data; valid only while done_o
- excepttype_o  out  32  0 none, 0x4 load misalign, 0x5 store misalign, 0x7 bus error; valid only while done_o
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  ADDR_W  address aligned to DATA_W/8
- bus_sel_o  out  DATA_W/8  byte enables
- bus_wdata_o  out  DATA_W  replicated store data
- bus_ack_i  in  1  bus completion
- bus_rdata_i  in  DATA_W  bus read data, valid with ack

Behaviour:
- Reset (rst=0 at a clock edge):
  - State returns to IDLE; the timeout counter clears.
  - All outputs go to 0, bus_sel_o included.
  - Reset mid-transaction abandons the access without producing done_o.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - stall_o = req_valid_i & ~flush_i, combinational.
  - On accept (req_valid_i=1, flush_i=0), latch we, size, signed, addr and wdata.
  - Misaligned access (addr mod size-bytes != 0, or size=3 with DATA_W=32): go to DONE with excepttype 0x4 if load, 0x5 if store; no bus cycle is issued.
  - Otherwise go to BUS.
- BUS:
  - stall_o=1.
  - bus_req_o, bus_we_o, bus_addr_o, bus_sel_o and bus_wdata_o are registered and held stable until the ack cycle.
  - Counter increments each cycle without ack.
  - Ack cycle: capture bus_rdata_i, go to DONE, excepttype 0.
  - Counter reaches TIMEOUT with no ack: drop bus_req_o, go to DONE, excepttype 0x7.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - done_o=1 and stall_o=0 for exactly one cycle, then return to IDLE.
  - req_valid_i is ignored in DONE; the pipeline advances at the end of this cycle.
- Lane select, big-endian default:
  - Byte offset o = addr[log2(DATA_W/8)-1:0]; lane k covers bits DATA_W-1-8k down to DATA_W-8-8k.
  - bus_sel_o has size-bytes contiguous ones starting at MSB-side bit (DATA_W/8-1-o).
  - bus_wdata_o = right-aligned store data replicated across all lanes.
  - rdata_o = selected lanes, extended to DATA_W per req_signed_i.
  - For loads, bus_sel_o equals the access bytes, not all ones.
- Flush:
  - flush_i in IDLE blocks accept.
  - flush_i in BUS sets a sticky cancel bit. The bus transaction still completes (ack or timeout), then the FSM returns to IDLE without passing through DONE; no done_o is produced and stall_o drops after ack.
  - flush_i in DONE suppresses done_o.
- Stores never write partially: a misaligned store never asserts bus_req_o.

Optional Feature:
- Macro: MEM_LITTLE_ENDIAN_EN.
- Defined: lane k maps to bits 8k+7 down to 8k, and bus_sel_o has ones starting at bit o going upward. Load extraction uses the same mapping.
- Undefined: big-endian mapping as specified in Behaviour.
- Alignment rules, handshake and timing are identical in both builds.

Test Plan:
- DATA_W=32, LB addr 0x1003, bus_rdata 0x112233F0, ack after 2 cycles -> bus_sel 0001, stall high 3 cycles, done_o with rdata 0xFFFFFFF0, excepttype 0. Same access as LBU -> rdata 0x000000F0.
- SH addr 0x2002, wdata 0x0000ABCD -> bus_we=1, bus_sel 0011, bus_wdata 0xABCDABCD, addr 0x2000. With MEM_LITTLE_ENDIAN_EN defined -> bus_sel 1100.
- LW addr 0x3001 -> no bus_req_o, done_o next cycle with excepttype 0x4. SW addr 0x3002 -> excepttype 0x5.
- TIMEOUT=4, LW with no ack -> bus_req_o high 4 cycles, then done_o with excepttype 0x7. Repeat with ack arriving in the 4th wait cycle -> excepttype 0 (ack wins).
- flush_i pulsed during BUS, ack 3 cycles later -> no done_o, FSM back in IDLE. rst=0 asserted during BUS -> all outputs 0 next cycle.
- DATA_W=64, LD addr 0x8 (dword) -> bus_sel 0xFF, rdata equals bus_rdata. LW addr 0xC -> bus_sel 0x0F, sign-extended rdata.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle MEM-stage load/store unit with a req/ack bus.
// Accepts one access from EX/MEM and stalls the pipeline until the bus completes.
// Returns lane-extracted, sign/zero-extended load data.
// Reports misalignment (0x4 load / 0x5 store) and bus timeout (0x7).
//
// Parameters: ADDR_W address width, DATA_W bus width (32|64), TIMEOUT ack wait limit (1..65535).
// Ports:
//   clk, rst (sync, active-low)
//   req_valid_i/req_we_i/req_size_i/req_signed_i/req_addr_i/req_wdata_i  request from EX/MEM
//   flush_i                                     discard current/pending access
//   stall_o, done_o, rdata_o, excepttype_o      pipeline side
//   bus_req_o/bus_we_o/bus_addr_o/bus_sel_o/bus_wdata_o, bus_ack_i/bus_rdata_i  bus side
// Build option: MEM_LITTLE_ENDIAN_EN selects little-endian lane mapping (big-endian otherwise).

module mem_access_unit #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_signed_i,
   input  logic [ADDR_W-1:0]     req_addr_i,
   input  logic [DATA_W-1:0]     req_wdata_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  done_o,
   output logic [DATA_W-1:0]     rdata_o,
   output logic [31:0]           excepttype_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [DATA_W/8-1:0]   bus_sel_o,
   output logic [DATA_W-1:0]     bus_wdata_o,
   input  logic                  bus_ack_i,
   input  logic [DATA_W-1:0]     bus_rdata_i
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam int unsigned CNT_W = 16;
   localparam int unsigned SH_W  = 7;
   localparam bit          NARROW = (DATA_W == 32);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [31:0] EXC_NONE = 32'h0;
   localparam logic [31:0] EXC_LMIS = 32'h4;
   localparam logic [31:0] EXC_SMIS = 32'h5;
   localparam logic [31:0] EXC_BUS  = 32'h7;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_cancel;
   logic               r_we;
   logic               r_signed;
   logic [3:0]         r_nbytes;
   logic [OFF_W-1:0]   r_off;

   logic               w_accept;
   logic               w_ack;
   logic               w_tmo;

   logic [3:0]         w_nbytes;
   logic [OFF_W-1:0]   w_off;
   logic [OFF_W-1:0]   w_lane_mask;
   logic               w_misalign;
   logic [NB-1:0]      w_ones;
   logic [NB-1:0]      w_sel;
   logic [DATA_W-1:0]  w_wdata_rep;

   logic [OFF_W+2:0]   w_lsh;
   logic [SH_W-1:0]    w_rsh;
   logic [DATA_W-1:0]  w_lane;
   logic [DATA_W-1:0]  w_ext;

   // Request decode: alignment, byte enables, replicated store data
   always_comb begin
      w_nbytes    = 4'd1 << req_size_i;
      w_off       = req_addr_i[OFF_W-1:0];
      w_lane_mask = OFF_W'(w_nbytes - 4'd1);
      // dword on a 32-bit bus can never be aligned
      w_misalign  = ((w_off & w_lane_mask) != '0) || (NARROW && (req_size_i == 2'd3));
      w_ones      = NB'((16'd1 << w_nbytes) - 16'd1);
`ifdef MEM_LITTLE_ENDIAN_EN
      w_sel       = w_ones << w_off;
`else
      w_sel       = (w_ones << (4'(NB) - w_nbytes)) >> w_off;
`endif
      w_wdata_rep = '0;
      // byte i of the bus carries store byte (i mod size); symmetric for both endiannesses
      for (int i = 0; i < NB; i++) begin
         w_wdata_rep[8*i +: 8] = req_wdata_i[8*(OFF_W'(i) & w_lane_mask) +: 8];
      end
   end

   // Load extraction: move selected lanes to the top, then shift down with extension
   always_comb begin
      w_lsh = {r_off, 3'b000};
      w_rsh = SH_W'(DATA_W) - {r_nbytes, 3'b000};
`ifdef MEM_LITTLE_ENDIAN_EN
      w_lane = (bus_rdata_i >> w_lsh) << w_rsh;
`else
      w_lane = bus_rdata_i << w_lsh;
`endif
      if (r_signed) begin
         w_ext = $unsigned($signed(w_lane) >>> w_rsh);
      end else begin
         w_ext = w_lane >> w_rsh;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and pipeline-side control
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_ack       = 1'b0;
      w_tmo       = 1'b0;
      stall_o     = 1'b0;
      done_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            stall_o  = req_valid_i & ~flush_i;
            w_accept = req_valid_i & ~flush_i;
            if (w_accept) begin
               w_state_nxt = w_misalign ? S_DONE : S_BUS;
            end
         end
         S_BUS: begin
            stall_o = 1'b1;
            // ack has priority over a same-cycle timeout
            w_ack   = bus_ack_i;
            w_tmo   = ~bus_ack_i && (r_cnt == TMO_LAST);
            if (w_ack || w_tmo) begin
               w_state_nxt = (r_cancel || flush_i) ? S_IDLE : S_DONE;
            end
         end
         S_DONE: begin
            done_o      = ~flush_i;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Request latch, bus drive, timeout counter and result capture
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt        <= '0;
         r_cancel     <= 1'b0;
         r_we         <= 1'b0;
         r_signed     <= 1'b0;
         r_nbytes     <= '0;
         r_off        <= '0;
         rdata_o      <= '0;
         excepttype_o <= '0;
         bus_req_o    <= 1'b0;
         bus_we_o     <= 1'b0;
         bus_addr_o   <= '0;
         bus_sel_o    <= '0;
         bus_wdata_o  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt    <= '0;
               r_cancel <= 1'b0;
               if (w_accept) begin
                  r_we     <= req_we_i;
                  r_signed <= req_signed_i;
                  r_nbytes <= w_nbytes;
                  r_off    <= w_off;
                  if (w_misalign) begin
                     excepttype_o <= req_we_i ? EXC_SMIS : EXC_LMIS;
                     rdata_o      <= '0;
                  end else begin
                     bus_req_o   <= 1'b1;
                     bus_we_o    <= req_we_i;
                     bus_addr_o  <= {req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                     bus_sel_o   <= w_sel;
                     bus_wdata_o <= w_wdata_rep;
                  end
               end
            end
            S_BUS: begin
               if (flush_i) begin
                  r_cancel <= 1'b1;
               end
               if (w_ack || w_tmo) begin
                  r_cnt        <= '0;
                  bus_req_o    <= 1'b0;
                  bus_we_o     <= 1'b0;
                  bus_addr_o   <= '0;
                  bus_sel_o    <= '0;
                  bus_wdata_o  <= '0;
                  excepttype_o <= w_ack ? EXC_NONE : EXC_BUS;
                  rdata_o      <= (w_ack && !r_we) ? w_ext : '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 32-bit instance (TIMEOUT=4) and 64-bit instance.
// Expected completions are queued at request time and popped on done pulses.
`timescale 1ns/1ps

module tb_mem_access_unit;

   localparam int unsigned TMO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_we, req_signed, flush, bus_ack;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, bus_rdata;
   logic        stall, done, bus_req, bus_we;
   logic [31:0] rdata, exc, bus_addr, bus_wdata;
   logic [3:0]  bus_sel;

   logic        d_req_valid, d_req_signed, d_bus_ack;
   logic [1:0]  d_req_size;
   logic [31:0] d_req_addr;
   logic [63:0] d_bus_rdata;
   logic        d_stall, d_done, d_bus_req, d_bus_we;
   logic [63:0] d_rdata, d_bus_wdata;
   logic [31:0] d_exc, d_bus_addr;
   logic [7:0]  d_bus_sel;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
      .req_signed_i(req_signed), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .flush_i(flush), .stall_o(stall), .done_o(done), .rdata_o(rdata),
      .excepttype_o(exc), .bus_req_o(bus_req), .bus_we_o(bus_we),
      .bus_addr_o(bus_addr), .bus_sel_o(bus_sel), .bus_wdata_o(bus_wdata),
      .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
   );

   mem_access_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(16)) u_dut64 (
      .clk(clk), .rst(rst),
      .req_valid_i(d_req_valid), .req_we_i(1'b0), .req_size_i(d_req_size),
      .req_signed_i(d_req_signed), .req_addr_i(d_req_addr), .req_wdata_i(64'd0),
      .flush_i(1'b0), .stall_o(d_stall), .done_o(d_done), .rdata_o(d_rdata),
      .excepttype_o(d_exc), .bus_req_o(d_bus_req), .bus_we_o(d_bus_we),
      .bus_addr_o(d_bus_addr), .bus_sel_o(d_bus_sel), .bus_wdata_o(d_bus_wdata),
      .bus_ack_i(d_bus_ack), .bus_rdata_i(d_bus_rdata)
   );

   typedef struct {
      logic [63:0] rdata;
      logic [31:0] exc;
      bit          chk_rd;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp64_q[$];
   exp_t mon_e;
   exp_t mon64_e;

   int n_checks;
   int n_errors;

   int          last_stalls, last_req;
   logic [3:0]  last_sel;
   logic [31:0] last_wdata, last_addr, last_rdata, last_exc;
   logic        last_we;
   logic [7:0]  last64_sel;
   logic [63:0] last64_rdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model
   function automatic bit m_mis(int nb, logic [1:0] sz, logic [31:0] addr);
      int n = 1 << sz;
      return (sz == 2'd3 && nb == 4) || ((addr % 32'(n)) != 32'd0);
   endfunction

   function automatic logic [7:0] m_sel(int nb, logic [1:0] sz, logic [31:0] addr);
      int n = 1 << sz;
      int o = int'(addr % 32'(nb));
      logic [7:0] s = '0;
      for (int j = 0; j < n; j++) begin
`ifdef MEM_LITTLE_ENDIAN_EN
         s[o + j] = 1'b1;
`else
         s[nb - 1 - o - j] = 1'b1;
`endif
      end
      return s;
   endfunction

   function automatic logic [63:0] m_rdata(int nb, logic [1:0] sz, logic sgn,
                                           logic [31:0] addr, logic [63:0] rd);
      int n = 1 << sz;
      int o = int'(addr % 32'(nb));
      logic [63:0] v = '0;
      logic [7:0]  b;
      for (int j = 0; j < n; j++) begin
`ifdef MEM_LITTLE_ENDIAN_EN
         b = rd[8*(o + j) +: 8];
         v = v | (64'(b) << (8*j));
`else
         b = rd[8*(nb - 1 - o - j) +: 8];
         v = (v << 8) | 64'(b);
`endif
      end
      if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   function automatic logic [31:0] m_wdata32(logic [1:0] sz, logic [31:0] wd);
      int n = 1 << sz;
      logic [31:0] v = '0;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
      return v;
   endfunction

   // Scoreboard monitors
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", 64'(done), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("excepttype", 64'(exc), 64'(mon_e.exc));
            if (mon_e.chk_rd) check("rdata", 64'(rdata), mon_e.rdata);
         end
      end
   end

   always @(negedge clk) begin
      if (d_done === 1'b1) begin
         if (exp64_q.size() == 0) begin
            check("d_done_unexpected", 64'(d_done), 64'd0);
         end else begin
            mon64_e = exp64_q.pop_front();
            check("d_excepttype", 64'(d_exc), 64'(mon64_e.exc));
            check("d_rdata", d_rdata, mon64_e.rdata);
         end
      end
   end

   // One access on the 32-bit unit; ack_at=0 means no ack (timeout), flush_at=0 means no flush
   task automatic tx32(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input int ack_at, input int flush_at);
      exp_t e;
      bit   mis;
      mis         = m_mis(4, sz, addr);
      last_stalls = 0;
      last_req    = 0;
      e.exc    = mis ? (we ? 32'h5 : 32'h4) : ((ack_at == 0) ? 32'h7 : 32'h0);
      e.chk_rd = !mis && !we && (ack_at != 0);
      e.rdata  = m_rdata(4, sz, sgn, addr, 64'(rd));
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
      req_addr = addr; req_wdata = wd; flush = 1'b0; bus_ack = 1'b0;
      @(negedge clk);
      check("stall_accept", 64'(stall), 64'd1);
      if (stall) last_stalls++;
      if (flush_at == 0) exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (!mis) begin
         for (int c = 1; c <= TMO; c++) begin
            bus_ack   = (c == ack_at);
            bus_rdata = (c == ack_at) ? rd : ~rd;
            flush     = (c == flush_at);
            @(negedge clk);
            if (stall) last_stalls++;
            if (bus_req) last_req++;
            check("bus_req", 64'(bus_req), 64'd1);
            check("bus_we", 64'(bus_we), 64'(we));
            check("bus_addr", 64'(bus_addr), 64'(addr & 32'hFFFF_FFFC));
            check("bus_sel", 64'(bus_sel), 64'(m_sel(4, sz, addr)));
            if (we) check("bus_wdata", 64'(bus_wdata), 64'(m_wdata32(sz, wd)));
            last_sel = bus_sel; last_wdata = bus_wdata; last_addr = bus_addr; last_we = bus_we;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            flush   = 1'b0;
            if (c == ack_at) break;
         end
      end
      @(negedge clk);
      check("done", 64'(done), (flush_at == 0) ? 64'd1 : 64'd0);
      check("stall_done", 64'(stall), 64'd0);
      check("bus_req_done", 64'(bus_req), 64'd0);
      last_rdata = rdata;
      last_exc   = exc;
   endtask

   // One load on the 64-bit unit, acked in its first bus cycle
   task automatic tx64(input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                       input logic [63:0] rd);
      exp_t e;
      e.exc    = 32'h0;
      e.chk_rd = 1'b1;
      e.rdata  = m_rdata(8, sz, sgn, addr, rd);
      @(posedge clk); #1;
      d_req_valid = 1'b1; d_req_size = sz; d_req_signed = sgn; d_req_addr = addr; d_bus_ack = 1'b0;
      exp64_q.push_back(e);
      @(posedge clk); #1;
      d_req_valid = 1'b0; d_bus_ack = 1'b1; d_bus_rdata = rd;
      @(negedge clk);
      check("d_bus_req", 64'(d_bus_req), 64'd1);
      check("d_bus_sel", 64'(d_bus_sel), 64'(m_sel(8, sz, addr)));
      check("d_bus_addr", 64'(d_bus_addr), 64'(addr & 32'hFFFF_FFF8));
      last64_sel = d_bus_sel;
      @(posedge clk); #1;
      d_bus_ack = 1'b0;
      @(negedge clk);
      check("d_done", 64'(d_done), 64'd1);
      last64_rdata = d_rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  sz;
      logic [31:0] addr;
      logic        we;
      int          ack_at, flush_at;

      n_checks = 0; n_errors = 0;
      rst = 1'b0;
      req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
      flush = 0; bus_ack = 0; bus_rdata = 0;
      d_req_valid = 0; d_req_size = 0; d_req_signed = 0; d_req_addr = 0; d_bus_ack = 0; d_bus_rdata = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_bus_req", 64'(bus_req), 64'd0);
      check("rst_bus_sel", 64'(bus_sel), 64'd0);
      check("rst_exc", 64'(exc), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_d_bus_sel", 64'(d_bus_sel), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // LB / LBU at 0x1003, ack in 2nd bus cycle
      tx32(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h112233F0, 2, 0);
      check("lb_stalls", 64'(last_stalls), 64'd3);
      check("lb_exc", 64'(last_exc), 64'd0);
`ifdef MEM_LITTLE_ENDIAN_EN
      check("lb_sel", 64'(last_sel), 64'h8);
      check("lb_rdata", 64'(last_rdata), 64'h0000_0011);
`else
      check("lb_sel", 64'(last_sel), 64'h1);
      check("lb_rdata", 64'(last_rdata), 64'hFFFF_FFF0);
`endif
      tx32(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h112233F0, 2, 0);
`ifdef MEM_LITTLE_ENDIAN_EN
      check("lbu_rdata", 64'(last_rdata), 64'h0000_0011);
`else
      check("lbu_rdata", 64'(last_rdata), 64'h0000_00F0);
`endif

      // SH at 0x2002
      tx32(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h0, 1, 0);
      check("sh_we", 64'(last_we), 64'd1);
      check("sh_wdata", 64'(last_wdata), 64'hABCD_ABCD);
      check("sh_addr", 64'(last_addr), 64'h2000);
`ifdef MEM_LITTLE_ENDIAN_EN
      check("sh_sel", 64'(last_sel), 64'hC);
`else
      check("sh_sel", 64'(last_sel), 64'h3);
`endif

      // Misaligned load and store
      tx32(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 1, 0);
      check("lw_mis_exc", 64'(last_exc), 64'h4);
      tx32(1'b1, 2'd2, 1'b0, 32'h3002, 32'h1, 32'h0, 1, 0);
      check("sw_mis_exc", 64'(last_exc), 64'h5);

      // Timeout, then ack in the final wait cycle
      tx32(1'b0, 2'd2, 1'b1, 32'h0100, 32'h0, 32'h0, 0, 0);
      check("tmo_req_cycles", 64'(last_req), 64'd4);
      check("tmo_exc", 64'(last_exc), 64'h7);
      tx32(1'b0, 2'd2, 1'b1, 32'h0104, 32'h0, 32'h8765_4321, 4, 0);
      check("ack_wins_exc", 64'(last_exc), 64'h0);
      check("ack_wins_rdata", 64'(last_rdata), 64'h8765_4321);

      // Flush during BUS: transaction completes silently
      tx32(1'b0, 2'd2, 1'b0, 32'h0200, 32'h0, 32'h5555_AAAA, 4, 1);
      tx32(1'b0, 2'd1, 1'b1, 32'h0206, 32'h0, 32'h0000_8001, 1, 0);

      // Flush in IDLE blocks accept
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h4000; flush = 1'b1;
      @(negedge clk);
      check("flush_idle_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_idle_noreq", 64'(bus_req), 64'd0);
      check("flush_idle_nodone", 64'(done), 64'd0);

      // Flush in DONE suppresses the pulse (misaligned load leaves excepttype 0x4)
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h3001;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      check("flush_done_suppress", 64'(done), 64'd0);
      check("flush_done_noreq", 64'(bus_req), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;

      // Reset during BUS abandons the access
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h5004; req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_pre_req", 64'(bus_req), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_stall", 64'(stall), 64'd0);
      check("rst_mid_done", 64'(done), 64'd0);
      check("rst_mid_rdata", 64'(rdata), 64'd0);
      check("rst_mid_exc", 64'(exc), 64'd0);
      check("rst_mid_req", 64'(bus_req), 64'd0);
      check("rst_mid_we", 64'(bus_we), 64'd0);
      check("rst_mid_addr", 64'(bus_addr), 64'd0);
      check("rst_mid_sel", 64'(bus_sel), 64'd0);
      check("rst_mid_wdata", 64'(bus_wdata), 64'd0);
      repeat (2) @(posedge clk);

      // Random mix of aligned/misaligned accesses, acks, timeouts and flushes
      for (int k = 0; k < 24; k++) begin
         sz       = 2'($urandom_range(0, 3));
         addr     = $urandom & 32'h0000_FFFF;
         we       = 1'($urandom_range(0, 1));
         ack_at   = $urandom_range(0, 4);
         flush_at = 0;
         if (!m_mis(4, sz, addr) && $urandom_range(0, 4) == 0)
            flush_at = $urandom_range(1, (ack_at == 0) ? TMO : ack_at);
         tx32(we, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom, ack_at, flush_at);
      end

      // 64-bit bus: LD and sign-extended LW
      tx64(2'd3, 1'b0, 32'h0008, 64'h0123_4567_89AB_CDEF);
      check("ld_sel", 64'(last64_sel), 64'hFF);
      check("ld_rdata", last64_rdata, 64'h0123_4567_89AB_CDEF);
      tx64(2'd2, 1'b1, 32'h000C, 64'h8000_0001_8000_0001);
`ifdef MEM_LITTLE_ENDIAN_EN
      check("lw64_sel", 64'(last64_sel), 64'hF0);
`else
      check("lw64_sel", 64'(last64_sel), 64'h0F);
`endif
      check("lw64_rdata", last64_rdata, 64'hFFFF_FFFF_8000_0001);
      tx64(2'd1, 1'b0, 32'h0016, 64'hFEDC_BA98_7654_3210);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("queue64_drained", 64'(exp64_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
